srl_feed_serializer: RTL
========================

# srl_feed_serializer

Parallel-to-serial front end that feeds an enabled shift-register chain (SRL16E-style delay line) with a serial bit `q` and shift strobe `e`. It accepts words over a valid/ready handshake and emits them LSB-first, one bit per enabled cycle. A downstream `hold` pauses emission without losing data. It sits directly upstream of the inferred SRL delay stage, which consumes `q`/`e` on its data/enable pins.

## Interface
- `WIDTH`, 8: bits per input word, minimum 2.
- `FLUSH_LEN`, 8: zero bits emitted after a last word; only used with the flush feature.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: block can accept a word this cycle.
- `s_data` in WIDTH: input word, transmitted LSB-first.
- `s_last` in 1: marks the final word of a burst; ignored unless `SRL_FEED_FLUSH_EN` is defined.
- `hold` in 1: downstream stall; when 1, `e` is 0 and no bit is consumed.
- `q` out 1: serial data bit to the shift chain.
- `e` out 1: shift enable; the chain shifts `q` in on edges where `e`=1.
- `busy` out 1: 1 when the state is not IDLE.

## Operation
- FSM states:
  - IDLE.
  - SHIFT: emitting data bits.
  - FLUSH: emitting zero bits; exists only with the macro.
- Registers:
  - `shreg[WIDTH-1:0]`: word being shifted out.
  - `bitcnt`: width `$clog2(max(WIDTH,FLUSH_LEN))`.
  - `last_q`: latched `s_last`.
  - `state`.
- Accept occurs when `s_valid && s_ready`. The accept edge loads `shreg`←`s_data`, `bitcnt`←0, `last_q`←`s_last`, and moves to SHIFT.
- `q` = `shreg[0]` in SHIFT; 0 in IDLE and FLUSH.
- `e` = (state∈{SHIFT,FLUSH}) && !`hold`.
- On each edge with `e`=1 in SHIFT: `shreg` shifts right by 1 and `bitcnt` increments.
- When `bitcnt`==WIDTH-1 and `e`=1, the last bit is consumed. Next state:
  - SHIFT, if a new word is accepted on the same edge (back-to-back).
  - FLUSH, if `last_q` is set and the macro is defined.
  - IDLE, otherwise.
- `s_ready` = (state==IDLE) || (state==SHIFT && `bitcnt`==WIDTH-1 && !`hold`). It is combinational and never depends on `s_valid`.
- FLUSH:
  - Emits FLUSH_LEN bits with `q`=0, counted on `e`=1 edges.
  - `s_ready`=0 throughout.
  - Returns to IDLE after the last zero bit.
- `hold`:
  - Freezes `shreg`, `bitcnt` and `state`; `q` stays stable.
  - `hold`=1 on the final bit also forces `s_ready`=0.
- Reset while `rst_n` is low:
  - State IDLE; `shreg`, `bitcnt` and `last_q` are 0.
  - `q`=0, `e`=0, `busy`=0, `s_ready`=1.
  - A word in flight is discarded, with no partial completion.

## Timing
- Latency: accept on edge N puts bit 0 on `q` with `e`=1 in cycle N+1. With no hold, bit k appears in cycle N+1+k.
- Throughput: back-to-back words give exactly one bit per cycle and no bubble, because `s_ready` rises during the last-bit cycle.
- A word with no hold occupies exactly WIDTH cycles. Each hold cycle adds one cycle.
- Simultaneous accept and last bit: the new word's bit 0 appears in the next cycle.
- Simultaneous `hold` and `s_valid` on the last bit: no accept, and the last bit is retained.
- Reset assertion is asynchronous: `e` drops in the same cycle. Deassertion is synchronous to the next rising edge.

## Configuration
- `SRL_FEED_FLUSH_EN` defined:
  - FLUSH state and `last_q` are present.
  - A word accepted with `s_last`=1 is followed by FLUSH_LEN zero bits.
  - This drains the downstream chain so its output holds the final word's bits.
- Not defined:
  - `s_last` is ignored; no FLUSH state or `last_q` logic is generated.
  - The FSM has only IDLE and SHIFT.

## Structure
- Package `srl_feed_pkg`:
  - `srl_feed_state_t` enum {IDLE, SHIFT, FLUSH}.
  - Default constants for WIDTH and FLUSH_LEN.
- One sub-module, `srl_feed_bitcnt`:
  - Parameterised up-counter with clear, increment enable, async active-low reset and a terminal-count compare.
  - Used for both the SHIFT and FLUSH counts.

## Test plan
- Single word 8'hA5, `hold`=0 → `q`=1,0,1,0,0,1,0,1 in cycles N+1..N+8, `e`=1 throughout; then `busy`=0 and `s_ready`=1.
- Back-to-back 8'hA5 then 8'h3C → 16 consecutive `e`=1 cycles; `s_ready`=1 in cycle N+8; a downstream 8-stage chain outputs the A5 bit sequence starting cycle N+9.
- 8'hF0 with `hold`=1 for 3 cycles starting at bit 4 → `e`=0 for those 3 cycles, `q` stable at 1, 8 enabled bits over 11 cycles.
- `rst_n` low during bit 3 of 8'hFF → `e`=0 and `q`=0 immediately; after release `busy`=0 and `s_ready`=1; the next word 8'h01 emits cleanly.
- With `SRL_FEED_FLUSH_EN`, FLUSH_LEN=8, word 8'h81 with `s_last`=1 → 8 data bits then 8 zero bits with `e`=1; `s_ready`=0 for 15 cycles after accept.
- Without the macro, the same stimulus → IDLE after 8 cycles and no zero bits.

Source files
------------

// File: rtl/srl_feed_pkg.sv
// rtl/srl_feed_pkg.sv - shared types and defaults for the SRL feed serializer
package srl_feed_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_FLUSH_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } srl_feed_state_t;

    // Counter must reach WIDTH-1 during data and FLUSH_LEN-1 during flush.
    function automatic int cnt_width(input int w, input int f);
        int m;
        m = (w > f) ? w : f;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/srl_feed_bitcnt.sv
// rtl/srl_feed_bitcnt.sv - up-counter with clear, enable and terminal-count compare
module srl_feed_bitcnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/srl_feed_serializer.sv
// rtl/srl_feed_serializer.sv - LSB-first word serializer feeding an SRL chain; SRL_FEED_FLUSH_EN adds zero-bit flush after s_last
module srl_feed_serializer
    import srl_feed_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FLUSH_LEN = DEF_FLUSH_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             hold,
    output logic             q,
    output logic             e,
    output logic             busy
);

    localparam int               CNT_W    = cnt_width(WIDTH, FLUSH_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    srl_feed_state_t  state;
    srl_feed_state_t  state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;
    logic [CNT_W-1:0] tc_val;
    logic             tc;
    logic             accept;
    logic             flush_req;

    assign e       = (state != IDLE) && !hold;
    assign q       = (state == SHIFT) ? shreg[0] : 1'b0;
    assign busy    = (state != IDLE);
    assign s_ready = (state == IDLE) || ((state == SHIFT) && tc && !hold);
    assign accept  = s_valid && s_ready;

`ifdef SRL_FEED_FLUSH_EN
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(FLUSH_LEN - 1);
    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else if (accept) begin
            last_q <= s_last;
        end
    end

    assign flush_req = last_q;
    assign tc_val    = (state == FLUSH) ? LAST_FLUSH : LAST_BIT;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign flush_req     = 1'b0;
    assign tc_val        = LAST_BIT;
`endif

    // One counter serves both phases; it restarts on every accept and phase end.
    srl_feed_bitcnt #(
        .W(CNT_W)
    ) u_bitcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept || (e && tc)),
        .inc    (e),
        .tc_val (tc_val),
        .cnt    (bitcnt),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (e && tc) begin
                    if (accept) state_nxt = SHIFT;
                    else        state_nxt = flush_req ? FLUSH : IDLE;
                end
            end
`ifdef SRL_FEED_FLUSH_EN
            FLUSH: begin
                if (e && tc) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= s_data;
        end else if ((state == SHIFT) && e) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

endmodule
